pixmem_fetch_arbiter: RTL
=========================

Name: pixmem_fetch_arbiter

Overview:
- Owns the single external pixel-memory read port: 9-bit word address, bank select, 3-bit pixel select, 4-bit pixel return after a fixed latency.
- Shares that port between two requesters:
  - Display line prefetcher (ch0): streams one scanline of pixels into an on-chip FIFO feeding the TMDS pixel path.
  - Auxiliary single-pixel reader (ch1): for sprite or host lookups.
- Sits inside the chip top, between the video timing/encoder logic and the external memory pins.

Parameters:
- RD_LAT, 2: cycles from a registered mem_* change to valid data on mem_pixel.
- DISP_LEN, 160: pixels fetched per disp_start; range 1..4095.
- FIFO_DEPTH, 16: display FIFO entries; power of two, minimum 4.
- AUX_MAX_WAIT, 8: cycles aux may be held off by display before it is forced a slot.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- disp_start  in  1  one-cycle pulse; begin or restart a line fetch
- disp_bank  in  1  bank for the line, sampled on disp_start
- disp_addr  in  9  base word address, sampled on disp_start
- disp_busy  out  1  line fetch issuing or in flight
- disp_pix_valid  out  1  FIFO non-empty
- disp_pix_ready  in  1  consumer pop
- disp_pix  out  4  FIFO head pixel (first-word fall-through)
- aux_req_valid  in  1  aux request
- aux_req_ready  out  1  aux grant this cycle
- aux_bank  in  1  aux bank
- aux_addr  in  9  aux word address
- aux_pix_sel  in  3  aux pixel select
- aux_rsp_valid  out  1  one-cycle response strobe; no backpressure
- aux_rsp_pixel  out  4  aux response data
- mem_addr  out  9  registered word address to external memory
- mem_bank  out  1  registered bank
- mem_pix_sel  out  3  registered pixel select
- mem_pixel  in  4  returned pixel

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0; FIFO empty; counters 0; tag pipeline cleared; display state IDLE.
- Issue slot: at most one read per cycle. An issue in cycle T registers mem_* at the end of T. mem_pixel is sampled RD_LAT cycles later.
- Aux timing: response at aux_rsp_valid in cycle T+RD_LAT+2 after handshake cycle T.
- Display timing: the pixel issued in cycle T is pushed into the FIFO at the end of cycle T+RD_LAT+1.
- No issue: mem_* hold their last value.
- Display state machine:
  - IDLE → FETCH on disp_start: latch bank/addr; pix_sel=0; remaining=DISP_LEN.
  - FETCH: each display issue drives the current addr/pix_sel and decrements remaining. pix_sel increments; on wrap 7→0, addr increments. addr wraps 511→0 and bank never changes.
  - FETCH → DRAIN when remaining reaches 0 after an issue.
  - DRAIN → IDLE once no display tag is in flight.
  - disp_busy = (state != IDLE).
- Display credit: issue only if fifo_count + disp_inflight < FIFO_DEPTH. The FIFO therefore never overflows. Push and pop in the same cycle are both allowed.
- Restart: disp_start in FETCH or DRAIN (or coincident with the last issue):
  - reload as from IDLE;
  - flush the FIFO in that cycle (disp_pix_valid 0 next cycle);
  - clear display tags in the pipeline, so old returns are discarded;
  - aux tags are unaffected.
- Tag pipeline: RD_LAT+1 stages of {valid, channel}. It routes each return to the FIFO or to aux_rsp.
- Arbitration per cycle:
  - Display wins if it is in FETCH and has credit, unless aux_wait == AUX_MAX_WAIT.
  - aux_req_ready = aux_req_valid and (display not eligible or aux_wait == AUX_MAX_WAIT).
  - Combinational aux_req_ready is the one permitted exception to registered outputs.
  - aux_wait increments each cycle aux_req_valid is held off. It saturates at AUX_MAX_WAIT and clears on aux grant or when aux_req_valid is low.
- Aux requests may be issued while the display is IDLE; they never affect display counters.
- Reset mid-operation: in-flight reads are discarded and no response is emitted.

Test Plan:
- Single line, consumer always ready: disp_addr=0x010, DISP_LEN=160.
  - mem_addr runs 0x010..0x023, pix_sel 0..7 each.
  - Exactly 160 pixels appear in order on disp_pix.
  - disp_busy falls RD_LAT+2 cycles after the last issue.
- Backpressure: disp_pix_ready=0.
  - Exactly FIFO_DEPTH reads are issued, then mem_* hold.
  - Asserting ready resumes issue with no lost or duplicated pixel.
- Address wrap: disp_addr=0x1FF, bank=1, DISP_LEN=16.
  - Words 0x1FF then 0x000 are read with bank=1 throughout.
- Aux starvation: aux_req_valid held through a display burst with AUX_MAX_WAIT=8.
  - Aux is granted on its 9th waiting cycle.
  - aux_rsp_pixel equals the memory model value at aux_addr/aux_pix_sel, RD_LAT+2 cycles after the grant.
  - Display resumes the next cycle.
- Restart mid-line: disp_start after 37 pixels issued, with new base 0x100.
  - FIFO empties next cycle.
  - No stale pixel from the old line is ever pushed.
  - 160 pixels come from 0x100 onward.
- Reset during an aux read: rst_n low for 1 cycle, 1 cycle after the grant.
  - No aux_rsp_valid occurs.
  - All outputs read 0 after reset.

Source files
------------

// File: rtl/pixmem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixmem_fetch_arbiter
// Brief    : Shares the external pixel-memory read port between the display
//            line prefetcher (into a fall-through FIFO) and an auxiliary
//            single-pixel reader, with a starvation bound for aux.
// Revision : 1.0 - initial release
// ============================================================================
module pixmem_fetch_arbiter #(
    parameter int RD_LAT       = 2,
    parameter int DISP_LEN     = 160,
    parameter int FIFO_DEPTH   = 16,
    parameter int AUX_MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       disp_start,
    input  logic       disp_bank,
    input  logic [8:0] disp_addr,
    output logic       disp_busy,
    output logic       disp_pix_valid,
    input  logic       disp_pix_ready,
    output logic [3:0] disp_pix,
    input  logic       aux_req_valid,
    output logic       aux_req_ready,
    input  logic       aux_bank,
    input  logic [8:0] aux_addr,
    input  logic [2:0] aux_pix_sel,
    output logic       aux_rsp_valid,
    output logic [3:0] aux_rsp_pixel,
    output logic [8:0] mem_addr,
    output logic       mem_bank,
    output logic [2:0] mem_pix_sel,
    input  logic [3:0] mem_pixel
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_sum_w  = c_cnt_w + $clog2(RD_LAT + 2);
    localparam int c_len_w  = 12;
    localparam int c_wait_w = $clog2(AUX_MAX_WAIT + 1);

    localparam logic [c_sum_w-1:0]  c_depth    = c_sum_w'(FIFO_DEPTH);
    localparam logic [c_len_w-1:0]  c_len      = c_len_w'(DISP_LEN);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(AUX_MAX_WAIT);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]          r_state;
    logic                r_bank;
    logic [8:0]          r_addr;
    logic [2:0]          r_pix_sel;
    logic [c_len_w-1:0]  r_remaining;
    // Tag pipeline: stage i holds the read issued i+1 cycles ago.
    logic [RD_LAT:0]     r_tag_v;
    logic [RD_LAT:0]     r_tag_aux;
    logic [3:0]          r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_wait_w-1:0] r_aux_wait;

    logic [c_sum_w-1:0]  w_inflight;
    logic                w_drain_done;
    logic                w_credit;
    logic                w_disp_elig;
    logic                w_aux_force;
    logic                w_disp_issue;
    logic                w_push;
    logic                w_pop;

    // Count display reads in flight; drain ends once the last one is at the output stage.
    always_comb begin
        w_inflight   = '0;
        w_drain_done = 1'b1;
        for (int i = 0; i <= RD_LAT; i++) begin
            if (r_tag_v[i] && !r_tag_aux[i]) begin
                w_inflight = w_inflight + c_sum_w'(1);
                if (i < RD_LAT) begin
                    w_drain_done = 1'b0;
                end
            end
        end
    end

    // Credit counts FIFO entries plus every display read still in flight, so a push always fits.
    assign w_credit      = (c_sum_w'(r_count) + w_inflight) < c_depth;
    // A restart pulse takes the cycle: no display issue while the line is being reloaded.
    assign w_disp_elig   = (r_state == c_st_fetch) && w_credit && !disp_start;
    assign w_aux_force   = (r_aux_wait == c_wait_max);
    assign aux_req_ready = aux_req_valid && (!w_disp_elig || w_aux_force);
    assign w_disp_issue  = w_disp_elig && !aux_req_ready;
    // Returns belonging to a line being restarted are dropped at the FIFO input.
    assign w_push        = r_tag_v[RD_LAT] && !r_tag_aux[RD_LAT] && !disp_start;
    assign w_pop         = disp_pix_ready && (r_count != '0) && !disp_start;

    assign disp_busy      = (r_state != c_st_idle);
    assign disp_pix_valid = (r_count != '0);
    assign disp_pix       = r_fifo[r_rd_ptr];

    // Register the memory request of whichever channel won the slot; hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_bank    <= 1'b0;
            mem_pix_sel <= '0;
        end else if (aux_req_ready) begin
            mem_addr    <= aux_addr;
            mem_bank    <= aux_bank;
            mem_pix_sel <= aux_pix_sel;
        end else if (w_disp_issue) begin
            mem_addr    <= r_addr;
            mem_bank    <= r_bank;
            mem_pix_sel <= r_pix_sel;
        end
    end

    // Display line state machine and address walk (9-bit word address wraps, bank fixed).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_bank      <= 1'b0;
            r_addr      <= '0;
            r_pix_sel   <= '0;
            r_remaining <= '0;
        end else if (disp_start) begin
            r_state     <= c_st_fetch;
            r_bank      <= disp_bank;
            r_addr      <= disp_addr;
            r_pix_sel   <= '0;
            r_remaining <= c_len;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (w_disp_issue) begin
                        r_pix_sel   <= r_pix_sel + 3'd1;
                        r_remaining <= r_remaining - c_len_w'(1);
                        if (r_pix_sel == 3'd7) begin
                            r_addr <= r_addr + 9'd1;
                        end
                        if (r_remaining == c_len_w'(1)) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_drain_done) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Shift read tags toward the return point; a restart kills display tags only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_v   <= '0;
            r_tag_aux <= '0;
        end else begin
            r_tag_v[0]   <= w_disp_issue || aux_req_ready;
            r_tag_aux[0] <= aux_req_ready;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1] && !(disp_start && !r_tag_aux[i-1]);
                r_tag_aux[i] <= r_tag_aux[i-1];
            end
        end
    end

    // Display FIFO with first-word fall-through head; flushed on restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (disp_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_pixel;
                r_wr_ptr         <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Aux response strobe, one cycle after the return is on mem_pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aux_rsp_valid <= 1'b0;
            aux_rsp_pixel <= '0;
        end else begin
            aux_rsp_valid <= r_tag_v[RD_LAT] && r_tag_aux[RD_LAT];
            if (r_tag_v[RD_LAT] && r_tag_aux[RD_LAT]) begin
                aux_rsp_pixel <= mem_pixel;
            end
        end
    end

    // Aux starvation counter: saturating, cleared on grant or when aux drops its request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aux_wait <= '0;
        end else if (!aux_req_valid || aux_req_ready) begin
            r_aux_wait <= '0;
        end else if (!w_aux_force) begin
            r_aux_wait <= r_aux_wait + c_wait_w'(1);
        end
    end

endmodule
`default_nettype wire
